// File: rtl/pc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_pkg : shared types and constants for the fetch-stage PC unit
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    HALTED   = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_target_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_target_mux : next-PC target computation and priority select (jr > j > br)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module pc_target_mux
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic            jr,
  input  logic [XLEN-1:0] branch_off_sl2,
  input  logic [25:0]     jump_idx,
  input  logic [XLEN-1:0] rs_val,
  output logic [XLEN-1:0] next_target,
  output logic            redirect
);

  logic            w_take_br;
  logic [XLEN-1:0] w_t_br;
  logic [XLEN-1:0] w_t_j;
  logic [XLEN-1:0] w_t_jr;
  pc_sel_e         w_sel;

  assign w_take_br = branch & zero;
  assign w_t_br    = pc_plus4 + branch_off_sl2;
  assign w_t_j     = {pc_plus4[XLEN-1:XLEN-4], jump_idx, 2'b00};
  // Low bits dropped: a misaligned target is either trapped upstream or forced to a word.
  assign w_t_jr    = rs_val & ~{{(XLEN-2){1'b0}}, 2'b11};

  always_comb begin
    w_sel = SEL_SEQ;
    if (jr)             w_sel = SEL_JR;
    else if (jump)      w_sel = SEL_J;
    else if (w_take_br) w_sel = SEL_BR;
  end

  always_comb begin
    next_target = pc_plus4;
    case (w_sel)
      SEL_BR:  next_target = w_t_br;
      SEL_J:   next_target = w_t_j;
      SEL_JR:  next_target = w_t_jr;
      default: next_target = pc_plus4;
    endcase
  end

  assign redirect = jr | jump | w_take_br;

endmodule : pc_target_mux
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_next_unit : PC register, redirect/halt FSM and wrong-path squash.
// Optional: PC_ALIGN_CHECK_EN traps misaligned JR targets into HALTED.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic            jr,
  input  logic            halt,
  input  logic [XLEN-1:0] branch_off_sl2,
  input  logic [25:0]     jump_idx,
  input  logic [XLEN-1:0] rs_val,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush,
  output logic            halted,
  output logic            misalign_err
);

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_flush;
  logic            r_halted;
  logic            r_misalign_err;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_target;
  logic            w_redirect;
  logic            w_misalign;

  assign w_pc_plus4 = r_pc + PC_STEP[XLEN-1:0];

  pc_target_mux #(
    .XLEN(XLEN)
  ) u_target_mux (
    .pc_plus4       (w_pc_plus4),
    .branch         (branch),
    .zero           (zero),
    .jump           (jump),
    .jr             (jr),
    .branch_off_sl2 (branch_off_sl2),
    .jump_idx       (jump_idx),
    .rs_val         (rs_val),
    .next_target    (w_next_target),
    .redirect       (w_redirect)
  );

`ifdef PC_ALIGN_CHECK_EN
  assign w_misalign = jr & (rs_val[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_pc           <= RESET_PC[XLEN-1:0];
      r_flush        <= 1'b0;
      r_halted       <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (en) begin
            if (halt) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end else if (w_misalign) begin
              r_state        <= HALTED;
              r_halted       <= 1'b1;
              r_misalign_err <= 1'b1;
            end else if (w_redirect) begin
              r_pc    <= w_next_target;
              r_state <= REDIRECT;
              r_flush <= 1'b1;
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        // Decode holds a wrong-path instruction here, so its control bits are ignored.
        REDIRECT: begin
          if (en) begin
            r_pc    <= w_pc_plus4;
            r_state <= RUN;
            r_flush <= 1'b0;
          end
        end
        HALTED: begin
          r_flush  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= HALTED;
          r_flush <= 1'b0;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign flush        = r_flush;
  assign halted       = r_halted;
  assign misalign_err = r_misalign_err;

endmodule : pc_next_unit
`default_nettype wire

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register and next-PC selector for the fetch stage of the MIPS datapath.
- Directly downstream of the word-offset shifter: consumes the already shifted branch offset (sign-extended immediate << 2) and the 26-bit jump index.
- Selects among sequential, branch, jump and jump-register targets, and holds the PC.
- Generates a one-cycle squash for the wrong-path instruction after any redirect, and supports stall and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath/PC width; fixed at 32 for this ISA, parameterised only for lint.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  PC write enable; 0 = stall (everything holds).
- branch  in  1  decoded BEQ-class instruction in decode.
- zero  in  1  ALU zero flag for that branch.
- jump  in  1  J/JAL in decode.
- jr  in  1  JR in decode.
- halt  in  1  halt instruction in decode.
- branch_off_sl2  in  32  sign-extended immediate shifted left by 2.
- jump_idx  in  26  instruction bits [25:0].
- rs_val  in  32  register rs value, the JR target.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc + 4 (combinational from pc).
- flush  out  1  squash the instruction now in decode (registered state decode).
- halted  out  1  core halted.
- misalign_err  out  1  sticky misaligned JR target (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=RUN, flush=0, halted=0, misalign_err=0.
- Reset mid-operation: immediately forces these values; any pending redirect is discarded.
- States:
  - RUN: normal fetch.
  - REDIRECT: one-cycle squash state.
  - HALTED: terminal until reset.
- Targets, all arithmetic mod 2^32:
  - seq = pc+4
  - br = pc_plus4 + branch_off_sl2
  - j = {pc_plus4[31:28], jump_idx, 2'b00}
  - jr = rs_val
- Priority: jr > jump > (branch & zero) > seq. Multiple control bits asserted together resolve by this priority.
- RUN, en=1:
  - halt=1: pc holds, go HALTED. Halt beats redirect in the same cycle.
  - Else a redirect (jr | jump | branch&zero): pc <= target, go REDIRECT.
  - Else: pc <= pc+4.
- REDIRECT, en=1:
  - All control inputs ignored, including halt, because the decode instruction is wrong-path.
  - pc <= pc+4, go RUN.
  - flush=1 throughout REDIRECT.
- en=0 in any state: pc, state and flush hold. A REDIRECT stalled for N cycles keeps flush=1 for N+1 cycles.
- HALTED: pc frozen, halted=1, flush=0, en ignored. Exit only by reset.
- Untaken branch (branch=1, zero=0): sequential path, no flush.
- Wrap-around: pc=32'hFFFF_FFFC advances to 32'h0000_0000 with no error.
- Latency: a redirect decision in cycle N is visible on pc in cycle N+1; flush is high in N+1.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: on an accepted jr with rs_val[1:0]!=0:
  - misalign_err sets (sticky until reset);
  - pc holds and state goes to HALTED;
  - no redirect, no flush.
- Undefined: misalign_err is tied 0 and the jr target is used as {rs_val[31:2], 2'b00}.
- The port exists in both builds.

Decomposition:
- Package pc_pkg holds:
  - state enum (RUN, REDIRECT, HALTED), 2-bit encoding;
  - next-PC select enum (SEL_SEQ, SEL_BR, SEL_J, SEL_JR);
  - PC_STEP constant = 4;
  - default RESET_PC constant.
- Sub-module pc_target_mux (combinational):
  - computes the four targets and the priority select;
  - outputs next_target and redirect.
- The top holds the PC register, FSM, and the optional alignment logic.

Test Plan:
- Reset then 3 cycles of en=1, no control -> pc = 0, 4, 8, 12; flush=0.
- pc=0x100, branch=1, zero=1, branch_off_sl2=0x20 -> next pc=0x124, flush=1 for one cycle. Control inputs during flush are ignored; then pc=0x128.
- pc=0x100, branch=1, zero=0 -> pc=0x104, no flush. In a separate cycle, jump=1 with jump_idx=0x0000040 at pc=0x1000_0000 -> pc=0x1000_0100.
- jr=1, jump=1, branch&zero all high, rs_val=0x400 -> pc=0x400 (jr wins). Then en=0 for 3 cycles -> pc=0x400, flush stays 1, then resumes to 0x404.
- halt=1 at pc=0x200 -> halted=1, pc stays 0x200 for 10 cycles regardless of en/jump. rst_n low mid-halt -> pc=RESET_PC, halted=0 asynchronously.
- With PC_ALIGN_CHECK_EN: jr with rs_val=0x402 -> misalign_err=1, halted=1, pc unchanged. Without the macro: pc=0x400, misalign_err=0.
